// File: rtl/gpio_pkg.sv
// Shared register map for the GPIO bank: per-port register offsets and select width.
// Pure declarations; no logic, no latency, no flow control.
// Optional debounce is controlled by the GPIO_DEBOUNCE_EN macro in the RTL files.
package gpio_pkg;

    localparam int unsigned REG_SEL_W = 3;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    localparam reg_sel_t REG_IN       = 3'd0;
    localparam reg_sel_t REG_OUT      = 3'd1;
    localparam reg_sel_t REG_DIR      = 3'd2;
    localparam reg_sel_t REG_SET      = 3'd3;
    localparam reg_sel_t REG_CLR      = 3'd4;
    localparam reg_sel_t REG_RISE_EN  = 3'd5;
    localparam reg_sel_t REG_FALL_EN  = 3'd6;
    localparam reg_sel_t REG_IRQ_STAT = 3'd7;

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: OUT/DIR/edge-enable registers, 2-flop input sync, edge capture into W1C status.
// Latency: pin->IN 2 cycles (plus up to 2 ticks with GPIO_DEBOUNCE_EN); IN->status 1 cycle.
// No backpressure: writes commit on the strobe cycle, read data is combinational from rd_sel.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  reg_sel_t      rd_sel,
    input  logic          wr_out,
    input  logic          wr_dir,
    input  logic          wr_set,
    input  logic          wr_clr,
    input  logic          wr_rise,
    input  logic          wr_fall,
    input  logic          wr_stat,
`ifdef GPIO_DEBOUNCE_EN
    input  logic          tick,
`endif
    input  logic [DW-1:0] pin,
    output logic [DW-1:0] out,
    output logic [DW-1:0] oe,
    output logic [DW-1:0] rdat,
    output logic          stat_any
);

    logic [DW-1:0] sync1, sync2, in_q, prev;
    logic [DW-1:0] rise_en, fall_en, stat;
    logic [DW-1:0] edge_hit, w1c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DW-1:0] samp, deb;

    // IN only moves to a level seen on two consecutive ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            deb  <= '0;
        end else if (tick) begin
            samp <= sync2;
            deb  <= (~(samp ^ sync2) & sync2) | ((samp ^ sync2) & deb);
        end
    end

    assign in_q = deb;
`else
    assign in_q = sync2;
`endif

    assign edge_hit = (in_q & ~prev & rise_en) | (~in_q & prev & fall_en);
    assign w1c      = wr_stat ? din : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            oe      <= '0;
            rise_en <= '0;
            fall_en <= '0;
            stat    <= '0;
            prev    <= '0;
        end else begin
            prev <= in_q;
            if (wr_out)      out <= din;
            else if (wr_set) out <= out | din;
            else if (wr_clr) out <= out & ~din;
            if (wr_dir)  oe      <= din;
            if (wr_rise) rise_en <= din;
            if (wr_fall) fall_en <= din;
            // A new edge overrides a same-cycle W1C on that bit.
            stat <= (stat & ~w1c) | edge_hit;
        end
    end

    assign stat_any = |stat;

    always_comb begin
        rdat = '0;
        case (rd_sel)
            REG_IN:       rdat = in_q;
            REG_OUT:      rdat = out;
            REG_DIR:      rdat = oe;
            REG_RISE_EN:  rdat = rise_en;
            REG_FALL_EN:  rdat = fall_en;
            REG_IRQ_STAT: rdat = stat;
            default:      rdat = '0;
        endcase
    end

endmodule

// File: rtl/gpio_bank.sv
// Multi-port memory-mapped GPIO bank with aggregated edge interrupt; GPIO_DEBOUNCE_EN adds a shared tick prescaler.
// Latency: reads 1 cycle (dout registered), irq registered 1 cycle after status changes.
// No backpressure: bus accepts one access per cycle, dout holds during write cycles.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 12,
    parameter int NPORT  = 2,
    parameter int DB_DIV = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       din,
    input  logic [AW-1:0]       addr,
    input  logic                we,
    output logic [DW-1:0]       dout,
    input  logic [NPORT*DW-1:0] gpio_in,
    output logic [NPORT*DW-1:0] gpio_out,
    output logic [NPORT*DW-1:0] gpio_oe,
    output logic                irq
);

    localparam int PW = AW - REG_SEL_W;

    logic [PW-1:0]    port_idx;
    reg_sel_t         rsel;
    logic [DW-1:0]    rdat [NPORT];
    logic [NPORT-1:0] stat_any;
    logic [DW-1:0]    rd_mux;

    assign port_idx = addr[AW-1:REG_SEL_W];
    assign rsel     = addr[REG_SEL_W-1:0];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;
    logic [CW-1:0] db_cnt;
    logic          tick;

    assign tick = (db_cnt == CW'(DB_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    db_cnt <= '0;
        else if (tick) db_cnt <= '0;
        else           db_cnt <= db_cnt + 1'b1;
    end
`endif

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic hit;
        assign hit = we && (port_idx == PW'(p));

        gpio_port #(.DW(DW)) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (din),
            .rd_sel   (rsel),
            .wr_out   (hit && (rsel == REG_OUT)),
            .wr_dir   (hit && (rsel == REG_DIR)),
            .wr_set   (hit && (rsel == REG_SET)),
            .wr_clr   (hit && (rsel == REG_CLR)),
            .wr_rise  (hit && (rsel == REG_RISE_EN)),
            .wr_fall  (hit && (rsel == REG_FALL_EN)),
            .wr_stat  (hit && (rsel == REG_IRQ_STAT)),
`ifdef GPIO_DEBOUNCE_EN
            .tick     (tick),
`endif
            .pin      (gpio_in[p*DW +: DW]),
            .out      (gpio_out[p*DW +: DW]),
            .oe       (gpio_oe[p*DW +: DW]),
            .rdat     (rdat[p]),
            .stat_any (stat_any[p])
        );
    end

    // Out-of-range port indices match no instance and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (port_idx == PW'(i)) rd_mux = rdat[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            irq  <= 1'b0;
        end else begin
            if (!we) dout <= rd_mux;
            irq <= |stat_any;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank: reset, OUT/SET/CLR, input sync latency, edge IRQ, W1C collision, unmapped access.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_gpio_bank;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NPORT = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DW-1:0]       din;
    logic [AW-1:0]       addr;
    logic                we;
    logic [DW-1:0]       dout;
    logic [NPORT*DW-1:0] gpio_in;
    logic [NPORT*DW-1:0] gpio_out;
    logic [NPORT*DW-1:0] gpio_oe;
    logic                irq;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_bank #(.DW(DW), .AW(AW), .NPORT(NPORT), .DB_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .addr     (addr),
        .we       (we),
        .dout     (dout),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        d = dout;
    endtask

    task automatic test_reset;
        logic [DW-1:0] r;
        rst_n = 1'b0; din = '0; addr = '0; we = 1'b0; gpio_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (gpio_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", gpio_out); end
        n_checks++; if (gpio_oe !== '0) begin n_fail++; $display("FAIL reset_oe: got %h want 0", gpio_oe); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        wr(12'h001, 16'h1234);
        wr(12'h002, 16'h00FF);
        rd(12'h001, r);
        n_checks++; if (r !== 16'h1234) begin n_fail++; $display("FAIL pre_reset_rd: got %h want 1234", r); end
        // Reset asserted while an OUT=FFFF write is being presented.
        @(negedge clk);
        addr = 12'h001; din = 16'hFFFF; we = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (gpio_out !== '0) begin n_fail++; $display("FAIL midrst_out: got %h want 0", gpio_out); end
        n_checks++; if (gpio_oe !== '0) begin n_fail++; $display("FAIL midrst_oe: got %h want 0", gpio_oe); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL midrst_dout: got %h want 0", dout); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq); end
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (gpio_out !== '0) begin n_fail++; $display("FAIL midrst_write_dropped: got %h want 0", gpio_out); end
        rd(12'h001, r);
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL post_rst_out_rd: got %h want 0", r); end
    endtask

    task automatic test_set_clear;
        logic [DW-1:0] r;
        wr(12'h009, 16'h00F0);
        wr(12'h00B, 16'h0F01);
        wr(12'h00C, 16'h00A0);
        rd(12'h009, r);
        n_checks++; if (r !== 16'h0F51) begin n_fail++; $display("FAIL setclr_rd: got %h want 0f51", r); end
        n_checks++; if (gpio_out !== 32'h0F51_0000) begin n_fail++; $display("FAIL setclr_pins: got %h want 0f510000", gpio_out); end
        // dout must hold across a write cycle.
        @(negedge clk);
        addr = 12'h00A; din = 16'hFF00; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        n_checks++; if (dout !== 16'h0F51) begin n_fail++; $display("FAIL dout_hold_on_write: got %h want 0f51", dout); end
        n_checks++; if (gpio_oe !== 32'hFF00_0000) begin n_fail++; $display("FAIL dir_pins: got %h want ff000000", gpio_oe); end
        rd(12'h00B, r);
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL set_reads_zero: got %h want 0", r); end
        rd(12'h00A, r);
        n_checks++; if (r !== 16'hFF00) begin n_fail++; $display("FAIL dir_rd: got %h want ff00", r); end
    endtask

    task automatic test_input_path;
        logic [DW-1:0] r;
        @(negedge clk);
        addr = 12'h000; we = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL in_idle: got %h want 0", dout); end
        gpio_in[15:0] = 16'hA5A5;
        @(negedge clk);
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL in_t1: got %h want 0", dout); end
        @(negedge clk);
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL in_t2: got %h want 0", dout); end
        @(negedge clk);
        n_checks++; if (dout !== 16'hA5A5) begin n_fail++; $display("FAIL in_t3: got %h want a5a5", dout); end
        rd(12'h008, r);
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL in_port1: got %h want 0", r); end
        gpio_in[15:0] = 16'h0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_edge_irq;
        logic [DW-1:0] r;
        wr(12'h005, 16'h0001);
        wr(12'h006, 16'h0000);
        rd(12'h007, r);
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL stat_clean: got %h want 0", r); end
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", irq); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq); end
        rd(12'h007, r);
        n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL stat_rise: got %h want 0001", r); end
        gpio_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        rd(12'h007, r);
        n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL stat_fall_ignored: got %h want 0001", r); end
        wr(12'h007, 16'h0001);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_w1c_lag: got %b want 1", irq); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", irq); end
        // Falling edge on bit1 only: rise there is not enabled.
        wr(12'h006, 16'h0002);
        gpio_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        rd(12'h007, r);
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL stat_rise_not_en: got %h want 0", r); end
        gpio_in[1] = 1'b0;
        repeat (6) @(negedge clk);
        rd(12'h007, r);
        n_checks++; if (r !== 16'h0002) begin n_fail++; $display("FAIL stat_fall: got %h want 0002", r); end
        wr(12'h007, 16'h0002);
        repeat (2) @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall_clr: got %b want 0", irq); end
    endtask

    task automatic test_collision;
        logic [DW-1:0] r;
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_setup: got %b want 1", irq); end
        gpio_in[0] = 1'b0;
        repeat (6) @(negedge clk);
        // New rise lands in status on the 3rd edge; W1C committed on that same edge.
        gpio_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr = 12'h007; din = 16'h0001; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq0: got %b want 1", irq); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq1: got %b want 1", irq); end
        rd(12'h007, r);
        n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL coll_stat: got %h want 0001", r); end
        wr(12'h007, 16'h0001);
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_cleanup: got %b want 0", irq); end
    endtask

    task automatic test_unmapped;
        logic [DW-1:0] r;
        rd(12'h009, r);
        n_checks++; if (r !== 16'h0F51) begin n_fail++; $display("FAIL unm_pre: got %h want 0f51", r); end
        wr(12'h010, 16'hFFFF);
        wr(12'h012, 16'hFFFF);
        wr(12'h017, 16'hFFFF);
        rd(12'h010, r);
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL unm_rd: got %h want 0", r); end
        n_checks++; if (gpio_out !== 32'h0F51_0000) begin n_fail++; $display("FAIL unm_out: got %h want 0f510000", gpio_out); end
        n_checks++; if (gpio_oe !== 32'hFF00_0000) begin n_fail++; $display("FAIL unm_oe: got %h want ff000000", gpio_oe); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL unm_irq: got %b want 0", irq); end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce;
        int seen;
        seen = 0;
        @(negedge clk);
        addr = 12'h000; we = 1'b0;
        gpio_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (dout[2]) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL db_glitch: got %0d high samples want 0", seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_set_clear();
        test_input_path();
        test_edge_irq();
        test_collision();
        test_unmapped();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
